// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor.
// Holds the FSM state encoding and the operation codes.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_adder_fulladder.sv
// One-bit combinational full-adder cell.
// serial_adder reuses this cell once per clock.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop, LSB-first.
// Result, carry-out and overflow are held until the next operation completes.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] MSB_CNT  = CNT_W'(WIDTH - 2);

  state_t           r_state;
  logic [WIDTH-1:0] r_aSh;
  logic [WIDTH-1:0] r_bSh;
  logic [WIDTH-1:0] r_resSh;
  logic             r_carry;
  logic             r_carryMsb;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  logic             w_sum;
  logic             w_cout;
  logic [WIDTH-1:0] w_resNext;

  fulladder u_cell (
    .a    (r_aSh[0]),
    .b    (r_bSh[0]),
    .cin  (r_carry),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // Shift formulation that stays legal for WIDTH=1.
  assign w_resNext = (r_resSh >> 1) | (WIDTH'(w_sum) << (WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_aSh      <= '0;
      r_bSh      <= '0;
      r_resSh    <= '0;
      r_carry    <= 1'b0;
      r_carryMsb <= 1'b0;
      r_cnt      <= '0;
      r_sum      <= '0;
      r_cout     <= 1'b0;
      r_ovf      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_aSh      <= a;
            r_bSh      <= (sub == OP_SUB) ? ~b : b;
            r_carry    <= cin ^ sub;
            // Seeding with the initial carry covers the single-bit case.
            r_carryMsb <= cin ^ sub;
            r_cnt      <= '0;
            r_busy     <= 1'b1;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          r_resSh <= w_resNext;
          r_aSh   <= r_aSh >> 1;
          r_bSh   <= r_bSh >> 1;
          r_carry <= w_cout;
          r_cnt   <= r_cnt + 1'b1;
          if ((WIDTH > 1) && (r_cnt == MSB_CNT)) begin
            r_carryMsb <= w_cout;
          end
          if (r_cnt == LAST_CNT) begin
            r_sum   <= w_resNext;
            r_cout  <= w_cout;
            r_ovf   <= w_cout ^ r_carryMsb;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 and WIDTH=1 instances checked
// against an arithmetic reference model.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst, start, sub, cin;
  logic [7:0] a, b, sum;
  logic       cout, ovf, busy, done;

  logic       start1, sub1, cin1;
  logic [0:0] a1, b1, sum1;
  logic       cout1, ovf1, busy1, done1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy), .done(done)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1), .cin(cin1),
    .sum(sum1), .cout(cout1), .ovf(ovf1), .busy(busy1), .done(done1)
  );

  // Reference: unsigned sum for result/carry, signed arithmetic for overflow.
  function automatic void model(input int w, input longint ua, input longint ub,
                                input bit s, input bit c, output longint rs,
                                output bit rc, output bit rv);
    longint mask, bb, tot, sa, sb, res, lim;
    mask = (64'sd1 <<< w) - 1;
    bb   = s ? (~ub & mask) : ub;
    tot  = ua + bb + longint'(c ^ s);
    rs   = tot & mask;
    rc   = tot[w];
    lim  = 64'sd1 <<< (w - 1);
    sa   = (ua >= lim) ? ua - (64'sd1 <<< w) : ua;
    sb   = (ub >= lim) ? ub - (64'sd1 <<< w) : ub;
    res  = s ? sa - sb - longint'(c) : sa + sb + longint'(c);
    rv   = (res >= lim) || (res < -lim);
  endfunction

  // Pulses start on the 8-bit DUT and returns cycles from the start edge to done.
  task automatic applyStimulus(input logic [7:0] ia, input logic [7:0] ib,
                               input bit is, input bit ic, output int lat);
    @(negedge clk);
    a = ia; b = ib; sub = is; cin = ic; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic checkOutput(input string name, input logic [7:0] ia,
                             input logic [7:0] ib, input bit is, input bit ic,
                             input int lat);
    longint es; bit ec, ev;
    model(8, longint'(ia), longint'(ib), is, ic, es, ec, ev);
    checks++;
    if (lat !== 8) begin
      errors++; $display("[TB] FAIL %s latency got %0d want 8", name, lat);
    end
    checks++;
    if ({sum, cout, ovf} !== {es[7:0], ec, ev}) begin
      errors++;
      $display("[TB] FAIL %s result got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
               name, sum, cout, ovf, es[7:0], ec, ev);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL %s pulse got done=%b busy=%b want 0 0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; start1 = 0; a = 0; b = 0; sub = 0; cin = 0;
    a1 = 0; b1 = 0; sub1 = 0; cin1 = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({sum, cout, ovf, busy, done} !== 12'h0) begin
      errors++; $display("[TB] FAIL reset got sum=%h cout=%b ovf=%b busy=%b done=%b want 0",
                         sum, cout, ovf, busy, done);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_directed();
    int lat;
    applyStimulus(8'h3C, 8'h5A, 1'b0, 1'b0, lat); checkOutput("add3C5A", 8'h3C, 8'h5A, 0, 0, lat);
    checks++;
    if ({sum, cout, ovf} !== {8'h96, 1'b0, 1'b1}) begin
      errors++; $display("[TB] FAIL add3C5A_const got %h %b %b want 96 0 1", sum, cout, ovf);
    end
    applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0, lat); checkOutput("addFF01", 8'hFF, 8'h01, 0, 0, lat);
    applyStimulus(8'hFF, 8'h01, 1'b0, 1'b1, lat); checkOutput("addFF01c", 8'hFF, 8'h01, 0, 1, lat);
    applyStimulus(8'h05, 8'h07, 1'b1, 1'b0, lat); checkOutput("sub0507", 8'h05, 8'h07, 1, 0, lat);
    checks++;
    if ({sum, cout, ovf} !== {8'hFE, 1'b0, 1'b0}) begin
      errors++; $display("[TB] FAIL sub0507_const got %h %b %b want FE 0 0", sum, cout, ovf);
    end
    applyStimulus(8'h80, 8'h01, 1'b1, 1'b0, lat); checkOutput("sub8001", 8'h80, 8'h01, 1, 0, lat);
    applyStimulus(8'h80, 8'h01, 1'b1, 1'b1, lat); checkOutput("sub8001b", 8'h80, 8'h01, 1, 1, lat);
  endtask

  task automatic test_random();
    int lat;
    logic [7:0] ra, rb;
    bit rs, rc;
    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      rs = 1'($urandom); rc = 1'($urandom);
      applyStimulus(ra, rb, rs, rc, lat);
      checkOutput("random", ra, rb, rs, rc, lat);
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    logic [7:0] prevSum;
    bit busyOk;
    prevSum = sum;
    @(negedge clk);
    a = 8'h21; b = 8'h13; sub = 0; cin = 0; start = 1'b1;
    @(posedge clk); #1;
    a = 8'hAA; b = 8'h77; sub = 1; cin = 1;
    busyOk = 1'b1;
    lat = 0;
    while (!done && lat < 40) begin
      busyOk &= (busy === 1'b1);
      if (lat == 1) start = 1'b0;
      if (lat < 7) begin
        checks++;
        if (sum !== prevSum) begin
          errors++; $display("[TB] FAIL hold got sum=%h want %h", sum, prevSum);
        end
      end
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (!busyOk) begin
      errors++; $display("[TB] FAIL ignore_busy got busy low during run want 1");
    end
    checkOutput("ignore", 8'h21, 8'h13, 0, 0, lat);
    start = 1'b0;
  endtask

  task automatic test_reset_abort();
    int lat;
    bit sawDone;
    @(negedge clk);
    a = 8'h7E; b = 8'h11; sub = 0; cin = 0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({sum, cout, ovf, busy, done} !== 12'h0) begin
      errors++; $display("[TB] FAIL abort got sum=%h cout=%b ovf=%b busy=%b done=%b want 0",
                         sum, cout, ovf, busy, done);
    end
    @(negedge clk); rst = 1'b0;
    sawDone = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      sawDone |= done;
    end
    checks++;
    if (sawDone || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL abort_nodone got done=%b busy=%b want 0 0", sawDone, busy);
    end
    applyStimulus(8'h7E, 8'h11, 1'b0, 1'b0, lat);
    checkOutput("after_abort", 8'h7E, 8'h11, 0, 0, lat);
  endtask

  task automatic test_width1();
    int lat;
    longint es; bit ec, ev;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      a1 = (k == 0) ? 1'b1 : 1'($urandom);
      b1 = (k == 0) ? 1'b1 : 1'($urandom);
      sub1 = (k == 0) ? 1'b0 : 1'($urandom);
      cin1 = (k == 0) ? 1'b1 : 1'($urandom);
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      lat = 0;
      while (!done1 && lat < 10) begin
        @(posedge clk); #1;
        lat++;
      end
      model(1, longint'(a1), longint'(b1), sub1, cin1, es, ec, ev);
      checks++;
      if (lat !== 1 || {sum1, cout1, ovf1} !== {es[0], ec, ev}) begin
        errors++;
        $display("[TB] FAIL width1 got lat=%0d sum=%b cout=%b ovf=%b want lat=1 sum=%b cout=%b ovf=%b",
                 lat, sum1, cout1, ovf1, es[0], ec, ev);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_abort();
    test_width1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised bit-serial adder/subtractor: one full-adder cell plus a carry flip-flop processes WIDTH-bit operands LSB-first, one bit per clock.
- Start/done handshake; result, carry-out and signed-overflow flag are held stable until the next operation completes.
- Used where area matters more than latency; successor to the 1-bit combinational full adder.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range >= 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- sub  input  1  0 = add, 1 = subtract; captured with operands.
- a  input  WIDTH  operand A; captured at accepted start.
- b  input  WIDTH  operand B; captured at accepted start.
- cin  input  1  carry-in (add) / borrow-in (sub); captured at accepted start.
- sum  output  WIDTH  result register.
- cout  output  1  raw carry out of MSB; for subtract 1 = no borrow.
- ovf  output  1  two's-complement overflow.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; sum=0, cout=0, ovf=0, busy=0, done=0; shift registers, carry and counter cleared. Reset dominates all other inputs.
- Reset mid-operation aborts the operation. No done pulse; sum/cout/ovf read 0.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge t:
  - a_sh<=a; b_sh<=(sub ? ~b : b); carry<=cin^sub; cnt<=0.
  - state<=RUN; busy=1 from the cycle after edge t.
  - With sub=1, cin=0 gives a-b; sub=1, cin=1 gives a-b-1.
- RUN, each edge:
  - Full-adder inputs are a_sh[0], b_sh[0], carry.
  - The sum bit shifts into the MSB of the result shift register; a_sh and b_sh shift right; carry<=cout of the cell; cnt<=cnt+1.
  - On the edge where cnt==WIDTH-2, record carry-into-MSB = carry-out of that bit. For WIDTH=1, carry-into-MSB = the initial carry.
  - On the edge where cnt==WIDTH-1 (the last bit):
    - sum<=completed shift value; cout<=cell cout.
    - ovf<=cell cout XOR carry-into-MSB.
    - state<=DONE.
- DONE: done=1 for exactly one cycle. Next edge: state<=IDLE, done=0, busy=0.
- Latency:
  - Start accepted at edge t -> done high in the cycle following edge t+WIDTH.
  - Next start is accepted no earlier than edge t+WIDTH+2.
- start in RUN or DONE is ignored (no queueing). Changes on a/b/sub/cin after acceptance do not affect the result.
- sum/cout/ovf change only at completion or reset; the previous result is held throughout RUN.
- Counter width $clog2(WIDTH+1); no wrap within an operation.

Decomposition:
- Shared package/header: state encoding localparams (S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2) and operation-code constants (OP_ADD=1'b0, OP_SUB=1'b1).
- One sub-module, instantiated once: fulladder (a, b, cin -> sum, cout), the 1-bit combinational cell. The control FSM, shift registers and carry flop stay in serial_adder.

Test Plan:
- WIDTH=8, add 8'h3C + 8'h5A, cin=0 -> sum=8'h96, cout=0, ovf=1; done exactly 8 cycles after start edge, one cycle wide.
- Add 8'hFF + 8'h01, cin=0 -> sum=8'h00, cout=1, ovf=0; repeat with cin=1 -> sum=8'h01, cout=1.
- Sub 8'h05 - 8'h07, cin=0 -> sum=8'hFE, cout=0, ovf=0; sub 8'h80 - 8'h01 -> sum=8'h7F, cout=1, ovf=1.
- Pulse start again and change a/b on the cycle after acceptance -> second start ignored, busy stays 1, result matches the original operands.
- Assert rst 4 cycles into a RUN -> next cycle busy=0, sum=0, no done; a fresh start afterwards completes correctly.
- WIDTH=1 build: 1+1, cin=1 -> sum=1, cout=1, ovf=0; done 1 cycle after start edge.
